// File: rtl/pipeline_elastic_reg_pkg.sv
// rtl/pipeline_elastic_reg_pkg.sv - shared stage-bundle widths and ring pointer sizing helper
package pipeline_elastic_reg_pkg;

    localparam int DATA_BUS_WIDTH = 32;

    // MEM->WB bundle layout: {mem_to_reg, reg_write, rd, mem_data, alu_result}
    localparam int MEMWB_ALU_OFFSET   = 0;
    localparam int MEMWB_MEM_OFFSET   = MEMWB_ALU_OFFSET + DATA_BUS_WIDTH;
    localparam int MEMWB_RD_OFFSET    = MEMWB_MEM_OFFSET + DATA_BUS_WIDTH;
    localparam int MEMWB_RW_OFFSET    = MEMWB_RD_OFFSET + 5;
    localparam int MEMWB_M2R_OFFSET   = MEMWB_RW_OFFSET + 1;
    localparam int MEMWB_BUNDLE_WIDTH = MEMWB_M2R_OFFSET + 1;

    function automatic int ring_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipeline_elastic_reg_ring_ptr.sv
// rtl/pipeline_elastic_reg_ring_ptr.sv - modulo-DEPTH pointer, wraps by compare so any DEPTH >= 1 is legal
module pipeline_elastic_reg_ring_ptr
    import pipeline_elastic_reg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = ring_ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/pipeline_elastic_reg.sv
// rtl/pipeline_elastic_reg.sv - elastic valid/ready stage register buffering DEPTH bundles with flush
// Define PIPE_ELASTIC_BYPASS_EN for a zero-latency path from input to output while empty.
module pipeline_elastic_reg
    import pipeline_elastic_reg_pkg::*;
#(
    parameter int WIDTH = DATA_BUS_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = ring_ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_rd;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign in_ready = ~w_full;

`ifdef PIPE_ELASTIC_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Bubbles read as zero so downstream stages never see stale storage.
    assign out_valid = ~w_empty | w_bypass;
    assign out_data  = ~w_empty ? r_mem[w_rd_ptr] : (w_bypass ? in_data : '0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;
    // A bypassed bundle consumed on arrival never touches storage.
    assign w_wr   = w_push & ~flush & ~(w_bypass & out_ready);
    assign w_rd   = w_pop & ~flush & ~w_bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    pipeline_elastic_reg_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_wr),
        .ptr (w_wr_ptr)
    );

    pipeline_elastic_reg_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_rd),
        .ptr (w_rd_ptr)
    );

    assign count = r_count;

endmodule

// File: tb/tb_pipeline_elastic_reg.sv
// tb/tb_pipeline_elastic_reg.sv - DEPTH=2 and DEPTH=3 instances checked against a queue model
module tb_pipeline_elastic_reg;

    localparam int W = 32;
`ifdef PIPE_ELASTIC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic         a_in_ready, a_out_valid;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_count;
    logic         b_in_ready, b_out_valid;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_count;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] popped_a[$];
    bit           a_ready_dropped;

    always #5 clk = ~clk;

    pipeline_elastic_reg #(.WIDTH(W), .DEPTH(2)) u_dut_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipeline_elastic_reg #(.WIDTH(W), .DEPTH(3)) u_dut_d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    task automatic expect_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int depth, input int sz, input logic [W-1:0] head,
                              input logic rdy, input logic vld, input logic [W-1:0] dat, input logic [1:0] cnt);
        bit bypass;
        bypass = BYP && sz == 0 && in_valid && !flush && !rst;
        expect_eq({nm, ".in_ready"},  W'(rdy), W'(sz < depth));
        expect_eq({nm, ".out_valid"}, W'(vld), W'(sz != 0 || bypass));
        expect_eq({nm, ".out_data"},  dat, (sz != 0) ? head : (bypass ? in_data : '0));
        expect_eq({nm, ".count"},     W'(cnt), W'(sz));
    endtask

    task automatic model_edge();
        bit byp, pop, push;
        if (rst || flush) begin
            qa.delete();
            qb.delete();
            return;
        end
        byp  = BYP && qa.size() == 0 && in_valid;
        pop  = out_ready && qa.size() != 0;
        push = in_valid && qa.size() < 2 && !(byp && out_ready);
        if (pop)  void'(qa.pop_front());
        if (push) qa.push_back(in_data);
        byp  = BYP && qb.size() == 0 && in_valid;
        pop  = out_ready && qb.size() != 0;
        push = in_valid && qb.size() < 3 && !(byp && out_ready);
        if (pop)  void'(qb.pop_front());
        if (push) qb.push_back(in_data);
    endtask

    task automatic step();
        @(negedge clk);
        check_inst("d2", 2, qa.size(), (qa.size() != 0) ? qa[0] : '0,
                   a_in_ready, a_out_valid, a_out_data, a_count);
        check_inst("d3", 3, qb.size(), (qb.size() != 0) ? qb[0] : '0,
                   b_in_ready, b_out_valid, b_out_data, b_count);
        if (a_out_valid && out_ready && !flush && !rst) popped_a.push_back(a_out_data);
        if (!a_in_ready) a_ready_dropped = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push_one(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2;
        expect_eq("por.count",     W'(a_count),     '0);
        expect_eq("por.out_valid", W'(a_out_valid), '0);
        expect_eq("por.out_data",  a_out_data,      '0);
        expect_eq("por.in_ready",  W'(a_in_ready),  W'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset between edges with two entries resident
        push_one(32'hA5A5_A5A5);
        push_one(32'h1111_1111);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_eq("arst.d2.count",     W'(a_count),     '0);
        expect_eq("arst.d2.out_valid", W'(a_out_valid), '0);
        expect_eq("arst.d2.out_data",  a_out_data,      '0);
        expect_eq("arst.d2.in_ready",  W'(a_in_ready),  W'(1));
        expect_eq("arst.d3.out_data",  b_out_data,      '0);
        qa.delete(); qb.delete();
        step();
        rst = 1'b0;
        push_one(32'h22);
        in_valid = 1'b0;
        #1;
        expect_eq("arst.head", a_out_data, 32'h22);
        idle(1);
        out_ready = 1'b1;
        idle(2);

        // Streaming with out_ready held high
        popped_a.delete();
        a_ready_dropped = 1'b0;
        for (int i = 1; i <= 8; i++) push_one(W'(i));
        idle(2);
        expect_eq("stream.npop", W'(popped_a.size()), W'(8));
        for (int i = 0; i < 8 && i < popped_a.size(); i++)
            expect_eq($sformatf("stream.pop%0d", i), popped_a[i], W'(i + 1));
        expect_eq("stream.ready_drop", W'(a_ready_dropped), '0);

        // Backpressure fill: third push refused until a slot frees
        popped_a.delete();
        out_ready = 1'b0;
        push_one(32'h10);
        push_one(32'h20);
        expect_eq("bp.count",    W'(a_count),    W'(2));
        expect_eq("bp.in_ready", W'(a_in_ready), '0);
        push_one(32'h30);
        out_ready = 1'b1;
        push_one(32'h30);
        push_one(32'h30);
        idle(4);
        expect_eq("bp.npop", W'(popped_a.size()), W'(3));
        if (popped_a.size() == 3) begin
            expect_eq("bp.pop0", popped_a[0], 32'h10);
            expect_eq("bp.pop1", popped_a[1], 32'h20);
            expect_eq("bp.pop2", popped_a[2], 32'h30);
        end

        // Full with simultaneous pop: pop happens, push refused
        out_ready = 1'b0;
        push_one(32'h41);
        push_one(32'h42);
        out_ready = 1'b1;
        push_one(32'h43);
        expect_eq("full.count", W'(a_count), W'(1));
        expect_eq("full.head",  a_out_data,  32'h42);
        idle(4);

        // Flush beats a same-cycle push and pop
        popped_a.delete();
        out_ready = 1'b0;
        push_one(32'h51);
        push_one(32'h52);
        flush = 1'b1; out_ready = 1'b1;
        push_one(32'hDEAD_BEEF);
        flush = 1'b0; in_valid = 1'b0;
        expect_eq("flush.count",     W'(a_count),     '0);
        expect_eq("flush.out_valid", W'(a_out_valid), '0);
        expect_eq("flush.out_data",  a_out_data,      '0);
        expect_eq("flush.in_ready",  W'(a_in_ready),  W'(1));
        idle(3);
        expect_eq("flush.npop", W'(popped_a.size()), '0);

        // Randomised traffic; the DEPTH=3 instance exercises non-power-of-2 wrap
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = (i < 40) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(4);

`ifdef PIPE_ELASTIC_BYPASS_EN
        // Empty buffer with a consuming sink: same-cycle pass-through, nothing stored
        in_valid = 1'b1; in_data = 32'hB0B0_B0B0; out_ready = 1'b1;
        #1;
        expect_eq("byp.out_valid", W'(a_out_valid), W'(1));
        expect_eq("byp.out_data",  a_out_data,      32'hB0B0_B0B0);
        step();
        in_valid = 1'b0;
        #1;
        expect_eq("byp.count", W'(a_count), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
